// File: rtl/dtpu_acc_pkg.sv
// Shared types and helpers for the smac column accumulator.
// Covers the precision codes, the FSM state type and the lane geometry.
package dtpu_acc_pkg;

  // Lane precision codes on select_precision; any other code behaves as INT64
  localparam logic [3:0] PREC_INT8  = 4'd0;
  localparam logic [3:0] PREC_INT16 = 4'd1;
  localparam logic [3:0] PREC_INT32 = 4'd2;
  localparam logic [3:0] PREC_INT64 = 4'd3;

  typedef enum logic {StIdle, StAcc} acc_state_e;

  // Signed clamp values per lane width, indexed by prec_idx()
  localparam logic [3:0][63:0] SAT_MAX = {
    64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_7FFF,
    64'h0000_0000_0000_007F
  };
  localparam logic [3:0][63:0] SAT_MIN = {
    64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_8000,
    64'h0000_0000_0000_0080
  };

  function automatic logic [1:0] prec_idx(input logic [3:0] prec);
    case (prec)
      PREC_INT8:  return 2'd0;
      PREC_INT16: return 2'd1;
      PREC_INT32: return 2'd2;
      default:    return 2'd3;
    endcase
  endfunction

  function automatic int unsigned lane_width(input logic [3:0] prec);
    return 32'd8 << prec_idx(prec);
  endfunction

  function automatic int unsigned lane_count(input int unsigned dw, input logic [3:0] prec);
    return dw / lane_width(prec);
  endfunction

endpackage

// File: rtl/acc_out_fifo.sv
// Synchronous result FIFO with full/empty flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module acc_out_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrW:0] PtrOne = 1;

  logic [Width-1:0] mem [Depth];
  logic [AddrW:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr_q[AddrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AddrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/smac_acc.sv
// Lane-wise accumulator for smac column partial sums.
// Groups are delimited by in_first/in_last; each closed group lands in an output FIFO.
module smac_acc
  import dtpu_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter string       SATURATE   = "NO"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  sclr,
  input  logic [3:0]            select_precision,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  overflow,
  output logic                  busy
);

  localparam bit Sat = (SATURATE == "YES");

  acc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [3:0]            prec_q, prec_d;
  logic                  ovf_q, ovf_d;
  logic                  accept, push, pop;
  logic                  fifo_full, fifo_empty, fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_rdata;

  // One lane-wise sum per precision; the latched precision picks one
  logic [3:0][DATA_WIDTH-1:0] sum_w;
  logic [3:0]                 ovf_w;

  for (genvar g = 0; g < 4; g++) begin : g_prec
    localparam logic [3:0]  Code = 4'(g);
    localparam int unsigned W    = lane_width(Code);
    localparam int unsigned N    = lane_count(DATA_WIDTH, Code);
    logic [N-1:0] lane_ovf;
    for (genvar l = 0; l < N; l++) begin : g_lane
      logic [W-1:0] a, b, s;
      assign a = acc_q[l*W +: W];
      assign b = in_data[l*W +: W];
      assign s = a + b;
      assign lane_ovf[l] = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      assign sum_w[g][l*W +: W] = (Sat && lane_ovf[l]) ?
                                  (a[W-1] ? SAT_MIN[g][W-1:0] : SAT_MAX[g][W-1:0]) : s;
    end
    assign ovf_w[g] = |lane_ovf;
  end

  assign in_ready   = ce & ~fifo_full & ~rst & ~sclr;
  assign accept     = in_valid & in_ready;
  assign fifo_valid = ~fifo_empty;
  assign out_valid  = fifo_valid & ~rst & ~sclr;
  assign pop        = out_valid & out_ready & ce;
  assign out_data   = out_valid ? fifo_rdata : '0;
  assign overflow   = ovf_q;
  assign busy       = (state_q == StAcc) | fifo_valid;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    prec_d  = prec_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    if (accept) begin
      push    = in_last;
      state_d = in_last ? StIdle : StAcc;
      if (in_first || (state_q == StIdle)) begin
        acc_d  = in_data;
        prec_d = select_precision;
      end else begin
        acc_d = sum_w[prec_idx(prec_q)];
        ovf_d = ovf_q | ovf_w[prec_idx(prec_q)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      prec_q  <= PREC_INT64;
      ovf_q   <= 1'b0;
    end else if (sclr) begin
      state_q <= StIdle;
      acc_q   <= '0;
      prec_q  <= PREC_INT64;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      prec_q  <= prec_d;
      ovf_q   <= ovf_d;
    end
  end

  acc_out_fifo #(
    .Width (DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (sclr),
    .push  (push),
    .pop   (pop),
    .wdata (acc_d),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_smac_acc.sv
// Self-checking bench for smac_acc: wrapping and saturating instances side by side,
// compared against a lane-arithmetic reference model.
module tb_smac_acc;

  logic        clk = 1'b0;
  logic        rst, ce, sclr, in_valid, in_first, in_last, out_ready;
  logic [3:0]  sel;
  logic [63:0] in_data;
  logic        in_ready, out_valid, overflow, busy;
  logic        in_ready_s, out_valid_s, overflow_s, busy_s;
  logic [63:0] out_data, out_data_s;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] got[$], got_s[$], exp_q[$], exp_s[$];
  bit          m_open, m_ovf, m_ovf_s;
  logic [63:0] m_acc, m_acc_s;
  logic [3:0]  m_prec;
  bit          rand_mode = 0;

  always #5 clk = ~clk;

  smac_acc #(.DATA_WIDTH(64), .FIFO_DEPTH(2), .SATURATE("NO")) dut (
    .clk(clk), .rst(rst), .ce(ce), .sclr(sclr), .select_precision(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_first(in_first),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .busy(busy)
  );

  smac_acc #(.DATA_WIDTH(64), .FIFO_DEPTH(2), .SATURATE("YES")) dut_sat (
    .clk(clk), .rst(rst), .ce(ce), .sclr(sclr), .select_precision(sel),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_first(in_first),
    .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .overflow(overflow_s), .busy(busy_s)
  );

  // Record every completed output handshake
  always @(posedge clk) begin
    if (out_valid && out_ready && ce) got.push_back(out_data);
    if (out_valid_s && out_ready && ce) got_s.push_back(out_data_s);
  end

  // Lane-wise signed add of two packed words using plain integer arithmetic
  function automatic logic [63:0] model_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] prec, input bit sat,
                                            output bit ovf);
    int w;
    logic [63:0] r;
    w = (prec == 4'd0) ? 8 : (prec == 4'd1) ? 16 : (prec == 4'd2) ? 32 : 64;
    r = '0;
    ovf = 0;
    for (int l = 0; l < 64 / w; l++) begin
      logic signed [66:0] half, sa, sb, ss;
      logic [66:0] mask, ua, ub;
      half = 67'sd1 <<< (w - 1);
      mask = (67'd1 << w) - 67'd1;
      ua = ({3'b000, a} >> (l * w)) & mask;
      ub = ({3'b000, b} >> (l * w)) & mask;
      sa = (ua ^ half) - half;
      sb = (ub ^ half) - half;
      ss = sa + sb;
      if (ss > half - 1 || ss < -half) begin
        ovf = 1;
        if (sat) ss = (ss > 0) ? half - 1 : -half;
      end
      r = r | (64'(ss & mask) << (l * w));
    end
    return r;
  endfunction

  task automatic model_beat(input logic [63:0] d, input bit first, input bit last);
    bit o, os;
    if (first || !m_open) begin
      m_acc = d; m_acc_s = d; m_prec = sel;
    end else begin
      m_acc   = model_add(m_acc, d, m_prec, 0, o);
      m_acc_s = model_add(m_acc_s, d, m_prec, 1, os);
      m_ovf   = m_ovf | o;
      m_ovf_s = m_ovf_s | os;
    end
    m_open = !last;
    if (last) begin
      exp_q.push_back(m_acc);
      exp_s.push_back(m_acc_s);
    end
  endtask

  task automatic model_clear();
    m_open = 0; m_ovf = 0; m_ovf_s = 0;
    got.delete(); got_s.delete(); exp_q.delete(); exp_s.delete();
  endtask

  // Present one beat and hold it until accepted; returns 1 ns after the accepting edge
  task automatic beat(input logic [63:0] d, input bit first, input bit last);
    int  n = 0;
    bit  acc;
    in_valid = 1; in_data = d; in_first = first; in_last = last;
    forever begin
      @(negedge clk);
      acc = in_ready && ce;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 60) begin
        n_checks++;
        $display("FAIL beat_timeout: beat %h never accepted within 60 cycles", d);
        break;
      end
    end
    in_valid = 0; in_first = 0; in_last = 0;
    if (acc) model_beat(d, first, last);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_checks++; if (out_data !== 64'd0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    idle(2);
    rst = 0;
    #1;
    model_clear();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL post_rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL post_rst_overflow: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_int64_basic();
    sel = 4'd3;
    beat(64'd5, 1, 0);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
    beat(64'd7, 0, 0);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid); else n_pass++;
    beat(64'd10, 0, 1);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL basic_latency: got %b want 1", out_valid); else n_pass++;
    n_checks++; if (out_data !== 64'd22) $display("FAIL basic_sum: got %0d want 22", out_data); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL basic_overflow: got %b want 0", overflow); else n_pass++;
    idle(2);
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_drain: got valid %b busy %b want 0 0", out_valid, busy); else n_pass++;
    n_checks++; if (got.size() != 1 || got[0] !== exp_q[0]) $display("FAIL basic_popped: got %0d items want 1 of %0d", got.size(), exp_q[0]); else n_pass++;
    model_clear();
  endtask

  task automatic test_int8_wrap_sat();
    sel = 4'd0;
    beat(64'h7F7F7F7F7F7F7F7F, 1, 0);
    beat(64'h0101010101010101, 0, 1);
    n_checks++; if (out_data !== 64'h8080808080808080) $display("FAIL int8_wrap: got %h want 8080808080808080", out_data); else n_pass++;
    n_checks++; if (out_data_s !== 64'h7F7F7F7F7F7F7F7F) $display("FAIL int8_sat: got %h want 7f7f7f7f7f7f7f7f", out_data_s); else n_pass++;
    n_checks++; if (overflow !== 1'b1 || overflow_s !== 1'b1) $display("FAIL int8_ovf: got %b %b want 1 1", overflow, overflow_s); else n_pass++;
    idle(2);
    sclr = 1;
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_data !== 64'd0) $display("FAIL sclr_outputs: got ready %b data %h want 0 0", in_ready, out_data); else n_pass++;
    @(posedge clk);
    #1;
    sclr = 0;
    n_checks++; if (overflow !== 1'b0 || overflow_s !== 1'b0) $display("FAIL sclr_overflow: got %b %b want 0 0", overflow, overflow_s); else n_pass++;
    model_clear();
  endtask

  task automatic test_backpressure();
    sel = 4'd3;
    out_ready = 0;
    beat(64'd1, 1, 1);
    beat(64'd2, 1, 1);
    in_valid = 1; in_data = 64'd3; in_first = 1; in_last = 1;
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", in_ready); else n_pass++;
      n_checks++; if (out_data !== 64'd1) $display("FAIL bp_stable: got %0d want 1", out_data); else n_pass++;
    end
    in_valid = 0;
    out_ready = 1;
    beat(64'd3, 1, 1);
    idle(4);
    n_checks++; if (got.size() != 3) $display("FAIL bp_count: got %0d want 3", got.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 64'(i + 1)) $display("FAIL bp_order: got %0d want %0d", got[i], i + 1); else n_pass++;
    end
    model_clear();
  endtask

  task automatic test_reset_midgroup();
    sel = 4'd1;
    beat({$urandom, $urandom}, 1, 0);
    beat({$urandom, $urandom}, 0, 0);
    #3;
    rst = 1;
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_data !== 64'd0 || out_valid !== 1'b0) $display("FAIL midrst_outputs: got ready %b data %h valid %b want 0", in_ready, out_data, out_valid); else n_pass++;
    @(posedge clk);
    #1;
    rst = 0;
    model_clear();
    n_checks++; if (busy !== 1'b0 || overflow !== 1'b0) $display("FAIL midrst_state: got busy %b ovf %b want 0 0", busy, overflow); else n_pass++;
    beat(64'h0001000100010001, 1, 1);
    n_checks++; if (out_data !== 64'h0001000100010001) $display("FAIL midrst_next: got %h want 0001000100010001", out_data); else n_pass++;
    beat(64'h0000000000000009, 0, 1);
    idle(3);
    n_checks++; if (got.size() != 2) $display("FAIL midrst_count: got %0d want 2", got.size()); else n_pass++;
    n_checks++; if (got.size() == 2 && got[1] !== 64'd9) $display("FAIL midrst_discard: got %h want 9", got[1]); else n_pass++;
    model_clear();
  endtask

  task automatic test_ce_hold();
    logic [63:0] d [4];
    sel = 4'd2;
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
    beat(d[0], 1, 0);
    beat(d[1], 0, 0);
    ce = 0;
    fork
      beat(d[2], 0, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          n_checks++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL ce_hold: got ready %b busy %b want 0 1", in_ready, busy); else n_pass++;
        end
        @(posedge clk);
        #2;
        ce = 1;
      end
    join
    beat(d[3], 0, 1);
    idle(3);
    n_checks++; if (got.size() != 1 || got[0] !== exp_q[0]) $display("FAIL ce_sum: got %0d items want 1 of %h", got.size(), exp_q[0]); else n_pass++;
    n_checks++; if (got_s.size() != 1 || got_s[0] !== exp_s[0]) $display("FAIL ce_sum_sat: got %0d items want 1 of %h", got_s.size(), exp_s[0]); else n_pass++;
    do_reset();
  endtask

  task automatic test_restart_and_prec();
    sel = 4'd3;
    beat(64'h7F, 1, 0);
    sel = 4'd0;
    beat(64'h01, 0, 1);
    n_checks++; if (out_data_s !== 64'h80) $display("FAIL prec_latched: got %h want 80", out_data_s); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL prec_ovf: got %b want 0", overflow); else n_pass++;
    sel = 4'd3;
    beat(64'd3, 1, 0);
    beat(64'd4, 0, 0);
    beat(64'd100, 1, 0);
    beat(64'd1, 0, 1);
    n_checks++; if (out_data !== 64'd101) $display("FAIL restart: got %0d want 101", out_data); else n_pass++;
    idle(3);
    model_clear();
  endtask

  task automatic test_random();
    do_reset();
    rand_mode = 1;
    fork
      begin
        for (int g = 0; g < 40; g++) begin
          int len;
          len = $urandom_range(1, 5);
          sel = 4'($urandom_range(0, 15));
          for (int b = 0; b < len; b++) begin
            bit first;
            first = (b == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            if (b > 0 && $urandom_range(0, 3) == 0) sel = 4'($urandom_range(0, 15));
            beat({$urandom, $urandom}, first, b == len - 1);
          end
        end
        rand_mode = 0;
      end
      while (rand_mode) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 2) != 0);
      end
    join
    out_ready = 1;
    idle(10);
    n_checks++; if (got.size() != exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
    n_checks++; if (got_s.size() != exp_s.size()) $display("FAIL rand_count_sat: got %0d want %0d", got_s.size(), exp_s.size()); else n_pass++;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got[i] !== exp_q[i]) $display("FAIL rand_wrap[%0d]: got %h want %h", i, got[i], exp_q[i]); else n_pass++;
    end
    for (int i = 0; i < got_s.size() && i < exp_s.size(); i++) begin
      n_checks++; if (got_s[i] !== exp_s[i]) $display("FAIL rand_sat[%0d]: got %h want %h", i, got_s[i], exp_s[i]); else n_pass++;
    end
    n_checks++; if (overflow !== m_ovf || overflow_s !== m_ovf_s) $display("FAIL rand_ovf: got %b %b want %b %b", overflow, overflow_s, m_ovf, m_ovf_s); else n_pass++;
  endtask

  initial begin
    rst = 1; ce = 1; sclr = 0; sel = 4'd3; out_ready = 1;
    in_valid = 0; in_first = 0; in_last = 0; in_data = '0;
    test_reset();
    test_int64_basic();
    test_int8_wrap_sat();
    test_backpressure();
    test_reset_midgroup();
    test_ce_hold();
    test_restart_and_prec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
